// File: rtl/bin2bcd_seq.sv
// Sequential signed-binary to BCD converter (double dabble, one bit per clock).
// Takes a two's-complement value and produces a sign flag plus DIGITS
// registered BCD digits. Requires 10**DIGITS > 2**(DATA_W-1) so that the
// magnitude of the most negative input still fits.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; captures sign and magnitude when it arrives
// SHIFT | one add-3 correction plus left shift per clock, DATA_W clocks
// DONE  | publishes the scratch digits and sign, pulses o_rdy
module bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  o_busy,
    output logic                  o_rdy,
    output logic                  o_sign,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] ONE   = 1;
    localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEC   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [DATA_W-1:0]  mag;
    logic [CNT_W-1:0]   cnt;
    logic               sign_r;

    // Add-3 correction on every scratch digit that would overflow past 9 after the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM with all outputs registered; o_rdy defaults low so it pulses once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            scratch <= '0;
            mag     <= '0;
            cnt     <= '0;
            sign_r  <= 1'b0;
            o_busy  <= 1'b0;
            o_rdy   <= 1'b0;
            o_sign  <= 1'b0;
            o_bcd   <= '0;
        end else begin
            o_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sign_r  <= i_data[DATA_W-1];
                        // the most negative input negates to itself, which is
                        // the correct unsigned magnitude
                        mag     <= i_data[DATA_W-1] ? (~i_data + ONE) : i_data;
                        scratch <= '0;
                        cnt     <= LOAD;
                        o_busy  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, mag} <= {scratch_adj[BCD_W-2:0], mag, 1'b0};
                    cnt            <= cnt - DEC;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_bcd  <= scratch;
                    // a zero result never reports negative
                    o_sign <= sign_r && (scratch != '0);
                    o_rdy  <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: reset, latency, busy window,
// back-to-back throughput, ignored starts, mid-conversion reset and a
// sweep of boundary and random values against a decimal reference.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_data;
    logic        o_busy;
    logic        o_rdy;
    logic        o_sign;
    logic [19:0] o_bcd;

    int checks;
    int failures;

    bin2bcd_seq #(.DATA_W(16), .DIGITS(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_data  (i_data),
        .o_busy  (o_busy),
        .o_rdy   (o_rdy),
        .o_sign  (o_sign),
        .o_bcd   (o_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with value v, then wait (bounded) for o_rdy.
    // lat = number of edges after the sampling edge until o_rdy is seen.
    task automatic run_conv(input logic [15:0] v, output int lat,
                            output logic [19:0] bcd, output logic sgn);
        i_start = 1'b1;
        i_data  = v;
        tick();
        i_start = 1'b0;
        i_data  = 16'($urandom);
        lat = 0;
        while (!o_rdy && lat < 40) begin
            tick();
            lat++;
        end
        bcd = o_bcd;
        sgn = o_sign;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        i_start = 1'b0;
        i_data  = 16'h0000;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_rdy !== 1'b0 || o_sign !== 1'b0 || o_bcd !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b rdy=%b sign=%b bcd=%h required all zero",
                     o_busy, o_rdy, o_sign, o_bcd);
        end
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b rdy=%b required 0 0", o_busy, o_rdy);
        end
    endtask

    task automatic test_zero();
        int lat;
        logic [19:0] bcd;
        logic sgn;
        run_conv(16'h0000, lat, bcd, sgn);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL zero_latency got=%0d required=17", lat);
        end
        checks++;
        if (bcd !== 20'h00000 || sgn !== 1'b0) begin
            failures++;
            $display("FAIL zero_value got bcd=%h sign=%b required 00000 0", bcd, sgn);
        end
        tick();
        checks++;
        if (o_rdy !== 1'b0) begin
            failures++;
            $display("FAIL zero_rdy_pulse got rdy=%b one cycle later required 0", o_rdy);
        end
    endtask

    task automatic test_negative();
        int busy_cnt = 0;
        int n = 0;
        logic held_ok = 1'b1;
        i_start = 1'b1;
        i_data  = 16'hC080; // -16256
        tick();
        i_start = 1'b0;
        while (o_busy && n < 40) begin
            if (o_bcd !== 20'h00000 || o_rdy !== 1'b0) held_ok = 1'b0;
            busy_cnt++;
            tick();
            n++;
        end
        checks++;
        if (busy_cnt !== 17) begin
            failures++;
            $display("FAIL neg_busy_cycles got=%0d required=17", busy_cnt);
        end
        checks++;
        if (held_ok !== 1'b1) begin
            failures++;
            $display("FAIL neg_outputs_held got=%b required=1", held_ok);
        end
        checks++;
        if (o_rdy !== 1'b1 || o_bcd !== 20'h16256 || o_sign !== 1'b1) begin
            failures++;
            $display("FAIL neg_value got rdy=%b bcd=%h sign=%b required 1 16256 1",
                     o_rdy, o_bcd, o_sign);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        i_start = 1'b1;
        i_data  = 16'h4000; // 16384
        tick();
        i_data  = 16'h8000; // -32768, sampled at the next IDLE edge
        while (!o_rdy && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 17 || o_bcd !== 20'h16384 || o_sign !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first got lat=%0d bcd=%h sign=%b required 17 16384 0",
                     n, o_bcd, o_sign);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_rdy && n < 40);
        i_start = 1'b0;
        checks++;
        if (n !== 18) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d required=18", n);
        end
        checks++;
        if (o_bcd !== 20'h32768 || o_sign !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second got bcd=%h sign=%b required 32768 1", o_bcd, o_sign);
        end
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stops got busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_ignore_start();
        int rdy_cnt = 0;
        logic [19:0] bcd_seen = 20'hFFFFF;
        logic sign_seen = 1'bx;
        i_start = 1'b1;
        i_data  = 16'h7FFF; // 32767
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 8) begin
                i_start = 1'b1;
                i_data  = 16'h0005;
            end
            if (c == 10) i_start = 1'b0;
            tick();
            if (o_rdy) begin
                rdy_cnt++;
                bcd_seen  = o_bcd;
                sign_seen = o_sign;
            end
        end
        checks++;
        if (rdy_cnt !== 1) begin
            failures++;
            $display("FAIL ignore_rdy_count got=%0d required=1", rdy_cnt);
        end
        checks++;
        if (bcd_seen !== 20'h32767 || sign_seen !== 1'b0) begin
            failures++;
            $display("FAIL ignore_value got bcd=%h sign=%b required 32767 0", bcd_seen, sign_seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int rdy_cnt = 0;
        logic [19:0] bcd;
        logic sgn;
        run_conv(16'hFFFF, lat, bcd, sgn);
        checks++;
        if (lat !== 17 || bcd !== 20'h00001 || sgn !== 1'b1) begin
            failures++;
            $display("FAIL minus_one got lat=%0d bcd=%h sign=%b required 17 00001 1", lat, bcd, sgn);
        end
        tick();
        i_start = 1'b1;
        i_data  = 16'd1234;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_rdy !== 1'b0 || o_sign !== 1'b0 || o_bcd !== 20'h0) begin
            failures++;
            $display("FAIL mid_reset got busy=%b rdy=%b sign=%b bcd=%h required all zero",
                     o_busy, o_rdy, o_sign, o_bcd);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (o_rdy) rdy_cnt++;
        end
        checks++;
        if (rdy_cnt !== 0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_rdy got rdy_count=%0d busy=%b required 0 0", rdy_cnt, o_busy);
        end
        run_conv(16'd1234, lat, bcd, sgn);
        checks++;
        if (lat !== 17 || bcd !== 20'h01234 || sgn !== 1'b0) begin
            failures++;
            $display("FAIL after_reset got lat=%0d bcd=%h sign=%b required 17 01234 0", lat, bcd, sgn);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [15:0] vals[$];
        int lat;
        logic [19:0] bcd;
        logic sgn;
        logic [19:0] exp_bcd;
        logic exp_sgn;
        int a;
        int m;
        logic digits_ok;
        vals = '{16'h0000, 16'h0001, 16'h0009, 16'h000A, 16'h0063, 16'h0064,
                 16'h270F, 16'h2710, 16'h7FFF, 16'h8000, 16'h8001, 16'hD8F0,
                 16'hFFF6, 16'hFFFF};
        for (int i = 0; i < 100; i++) vals.push_back(16'($urandom_range(0, 65535)));
        foreach (vals[i]) begin
            a = int'($signed(vals[i]));
            exp_sgn = (a < 0);
            m = (a < 0) ? -a : a;
            exp_bcd = '0;
            for (int k = 0; k < 5; k++) begin
                exp_bcd[4*k +: 4] = 4'(m % 10);
                m = m / 10;
            end
            run_conv(vals[i], lat, bcd, sgn);
            digits_ok = 1'b1;
            for (int k = 0; k < 5; k++) if (bcd[4*k +: 4] > 4'd9) digits_ok = 1'b0;
            checks++;
            if (lat !== 17 || bcd !== exp_bcd || sgn !== exp_sgn || digits_ok !== 1'b1) begin
                failures++;
                $display("FAIL sweep_%h got lat=%0d bcd=%h sign=%b required 17 %h %b",
                         vals[i], lat, bcd, sgn, exp_bcd, exp_sgn);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero();
        test_negative();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
